// File: rtl/uart_frame_rx_ctrl.sv
// uart_frame_rx_ctrl: parses sync/len/payload frames from uart_rx, buffers and drains the payload, owns uart_rx reset.
// Define UART_FRAME_CHECKSUM_EN to add a trailing modulo-256 check byte (length plus payload).
module uart_frame_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CYCLES = 480,
  parameter int RESYNC_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_rst,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RESYNC_CYCLES + 1);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  localparam logic [1:0] E_LEN = 2'd0, E_SUM = 2'd1, E_TMO = 2'd2, E_OVR = 2'd3;
  typedef enum logic [2:0] {
    IDLE, LEN, PAYLOAD,
`ifdef UART_FRAME_CHECKSUM_EN
    CHECK,
`endif
    DRAIN, RESYNC
  } state_t;
  state_t         state_q;
  logic [7:0]     len_q;
  logic [AW-1:0]  idx_q, rd_q;
  logic [TW-1:0]  tmo_q;
  logic [RW-1:0]  rs_q;
  logic           rx_rst_q, frame_ok_q, frame_err_q;
  logic [1:0]     err_code_q;
  logic [7:0]     buf_q [MAX_LEN];
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]     sum_q;
`endif
  logic in_frame, bad_len, bad_sum, tmo_err, err, last_in, last_rd;
  always_comb begin
    in_frame = state_q == LEN || state_q == PAYLOAD;
    bad_len  = state_q == LEN && rx_data_valid && (rx_data == 8'd0 || rx_data > MAX_B);
`ifdef UART_FRAME_CHECKSUM_EN
    in_frame = in_frame || state_q == CHECK;
    bad_sum  = state_q == CHECK && rx_data_valid && rx_data != sum_q;
`else
    bad_sum  = 1'b0;
`endif
    tmo_err  = in_frame && !rx_data_valid && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    err      = bad_len || bad_sum || tmo_err;
  end
  assign last_in   = 8'(idx_q) == len_q - 8'd1;
  assign last_rd   = 8'(rd_q) == len_q - 8'd1;
  assign out_valid = state_q == DRAIN;
  assign out_data  = out_valid ? buf_q[rd_q] : 8'd0;
  assign out_last  = out_valid && last_rd;
  assign rx_rst    = rx_rst_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  // Payload storage needs no reset: it is only read in DRAIN, after being written.
  always_ff @(posedge clk)
    if (state_q == PAYLOAD && rx_data_valid) buf_q[idx_q] <= rx_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESYNC;
      rs_q        <= RW'(RESYNC_CYCLES);
      rx_rst_q    <= 1'b1;
      len_q       <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tmo_q       <= rx_data_valid ? '0 : tmo_q + 1'b1;
      case (state_q)
        IDLE: if (rx_data_valid && rx_data == SYNC_BYTE) state_q <= LEN;
        LEN: if (rx_data_valid) begin
          len_q   <= rx_data;
          idx_q   <= '0;
          state_q <= PAYLOAD;
`ifdef UART_FRAME_CHECKSUM_EN
          sum_q   <= rx_data;
`endif
        end
        PAYLOAD: if (rx_data_valid) begin
          idx_q <= idx_q + 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
          sum_q <= sum_q + rx_data;
          if (last_in) state_q <= CHECK;
`else
          if (last_in) begin
            frame_ok_q <= 1'b1;
            rd_q       <= '0;
            state_q    <= DRAIN;
          end
`endif
        end
`ifdef UART_FRAME_CHECKSUM_EN
        CHECK: if (rx_data_valid) begin
          frame_ok_q <= 1'b1;
          rd_q       <= '0;
          state_q    <= DRAIN;
        end
`endif
        DRAIN: begin
          if (rx_data_valid) begin
            frame_err_q <= 1'b1;
            err_code_q  <= E_OVR;
          end
          if (out_ready) begin
            rd_q <= rd_q + 1'b1;
            if (last_rd) state_q <= IDLE;
          end
        end
        RESYNC: if (rs_q == RW'(1)) begin
          rx_rst_q <= 1'b0;
          state_q  <= IDLE;
        end else rs_q <= rs_q - 1'b1;
        default: state_q <= IDLE;
      endcase
      // Errors override whatever the state branch decided for this byte.
      if (err) begin
        frame_ok_q  <= 1'b0;
        frame_err_q <= 1'b1;
        err_code_q  <= bad_len ? E_LEN : bad_sum ? E_SUM : E_TMO;
        rx_rst_q    <= 1'b1;
        rs_q        <= RW'(RESYNC_CYCLES);
        state_q     <= RESYNC;
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_rx_ctrl.sv
// tb_uart_frame_rx_ctrl: directed and randomized frames checked against a queue-based frame model.
module tb_uart_frame_rx_ctrl;
  localparam int MAX_LEN = 16, TMO = 480, RS = 16;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, rx_data_valid = 1'b0, out_ready = 1'b0, rnd_ready = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic rx_rst, out_valid, out_last, frame_ok, frame_err;
  logic [7:0] out_data;
  logic [1:0] err_code;
  int n_chk = 0, n_err = 0, ok_cnt = 0;
  logic [7:0] got_d[$], pl[$];
  logic got_l[$];
  logic [1:0] errq[$];
  logic stall_q = 1'b0;
  logic [7:0] hold_d = 8'd0;

  always #5 clk = ~clk;

  uart_frame_rx_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO), .RESYNC_CYCLES(RS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_rst(rx_rst),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
    if (frame_ok) ok_cnt++;
    if (frame_err) errq.push_back(err_code);
    if (stall_q && out_valid) chk("stall_hold", out_data, hold_d);
    stall_q = out_valid && !out_ready;
    hold_d  = out_data;
  end

  always begin
    @(posedge clk); #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    rx_data = b;
    rx_data_valid = 1'b1;
    @(posedge clk); #1;
    rx_data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] len, input bit bad, input int gap);
    logic [7:0] s;
    s = len;
    send_byte(8'hA5, $urandom_range(0, gap));
    send_byte(len, $urandom_range(0, gap));
    if (len >= 1 && len <= MAX_LEN) begin
      foreach (pl[i]) begin
        send_byte(pl[i], $urandom_range(0, gap));
        s += pl[i];
      end
      if (CK) send_byte(bad ? s + 8'd1 : s, $urandom_range(0, gap));
    end
  endtask

  task automatic clr();
    got_d.delete(); got_l.delete(); errq.delete(); ok_cnt = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((out_valid || rx_rst) && n < 3000);
    chk("idle_reached", 32'(n < 3000), 1);
    @(posedge clk); #1;
  endtask

  task automatic count_rs(input string tag);
    int c = 0;
    while (c < 100) begin
      @(negedge clk);
      if (!rx_rst) break;
      c++;
    end
    chk(tag, c, RS);
    @(posedge clk); #1;
  endtask

  task automatic fill_rand(input int len);
    pl.delete();
    for (int i = 0; i < len && i < MAX_LEN; i++) pl.push_back(8'($urandom));
  endtask

  task automatic run_frame(input logic [7:0] len, input bit bad, input int gap);
    bit ok_len, good;
    logic [7:0] junk;
    ok_len = len >= 1 && len <= MAX_LEN;
    good = ok_len && !(CK && bad);
    clr();
    if ($urandom_range(0, 2) == 0) begin
      junk = 8'($urandom);
      send_byte(junk == 8'hA5 ? 8'h00 : junk, 0);
    end
    send_frame(len, bad, gap);
    wait_idle();
    chk("ok_cnt", ok_cnt, 32'(good));
    chk("err_cnt", errq.size(), 32'(!good));
    if (!good && errq.size() > 0) chk("err_code", errq[0], ok_len ? 1 : 0);
    chk("pl_cnt", got_d.size(), good ? 32'(len) : 0);
    if (good)
      for (int i = 0; i < pl.size() && i < got_d.size(); i++) begin
        chk("pl_data", got_d[i], pl[i]);
        chk("pl_last", got_l[i], 32'(i == pl.size() - 1));
      end
  endtask

  initial begin
    int k;
    logic [7:0] len;
    repeat (3) @(posedge clk); #1;
    chk("rst_rx_rst", rx_rst, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_code", err_code, 0);
    rst_n = 1'b1;
    count_rs("rst_release_rs");
    // Zero-wait drain of 11 22 33.
    clr(); out_ready = 1'b1;
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'd3, 1'b0, 0);
    @(negedge clk);
    chk("ok_pulse", frame_ok, 1);
    chk("first_valid", out_valid, 1);
    chk("d0", out_data, 8'h11);
    chk("l0", out_last, 0);
    @(negedge clk);
    chk("d1", out_data, 8'h22);
    chk("l1", out_last, 0);
    @(negedge clk);
    chk("d2", out_data, 8'h33);
    chk("l2", out_last, 1);
    @(negedge clk);
    chk("drained", out_valid, 0);
    chk("ok_once", ok_cnt, 1);
    @(posedge clk); #1;
    // Corrupted check byte (a good frame when no check byte is configured).
    run_frame(8'd3, 1'b1, 0);
    // Bad length: error code, rx_rst hold, recovery.
    clr();
    send_byte(8'hA5, 0); send_byte(8'h00, 0);
    chk("len0_err", frame_err, 1);
    chk("len0_code", err_code, 0);
    count_rs("len0_rs");
    fill_rand(5); run_frame(8'd5, 1'b0, 1);
    fill_rand(0); run_frame(8'h11, 1'b0, 0);
    // Timeout exactly TMO cycles after the last strobe.
    clr();
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!frame_err && k < 600);
    chk("tmo_cycles", k, TMO);
    chk("tmo_code", err_code, 2);
    chk("tmo_rx_rst", rx_rst, 1);
    wait_idle();
    // Strobe landing on the timeout compare wins.
    clr();
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    send_byte(8'h22, TMO - 1);
    send_byte(8'h33, 0);
    if (CK) send_byte(8'h69, 0);
    wait_idle();
    chk("tmo_race_err", errq.size(), 0);
    chk("tmo_race_ok", ok_cnt, 1);
    chk("tmo_race_cnt", got_d.size(), 3);
    // Stall in DRAIN with an overrun byte.
    clr(); out_ready = 1'b0;
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'd3, 1'b0, 0);
    @(negedge clk);
    chk("stall_valid", out_valid, 1);
    chk("stall_d0", out_data, 8'h11);
    @(posedge clk); #1;
    send_byte(8'h5A, 20);
    @(negedge clk);
    chk("ovr_err", frame_err, 1);
    chk("ovr_code", err_code, 3);
    chk("ovr_keeps_valid", out_valid, 1);
    @(posedge clk); #1;
    repeat (28) begin @(posedge clk); #1; end
    chk("stall_end_d0", out_data, 8'h11);
    out_ready = 1'b1;
    wait_idle();
    chk("stall_ok", ok_cnt, 1);
    chk("stall_cnt", got_d.size(), 3);
    for (int i = 0; i < 3 && i < got_d.size(); i++) chk("stall_data", got_d[i], pl[i]);
    // Asynchronous reset mid-payload.
    clr();
    send_byte(8'hA5, 0); send_byte(8'h05, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rx_rst", rx_rst, 1);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_data", out_data, 0);
    chk("mid_frame_ok", frame_ok, 0);
    chk("mid_frame_err", frame_err, 0);
    chk("mid_err_code", err_code, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_rs("mid_release_rs");
    repeat (20) begin @(posedge clk); #1; end
    chk("mid_no_data", got_d.size(), 0);
    chk("mid_no_ok", ok_cnt, 0);
    chk("mid_no_err", errq.size(), 0);
    // Randomized frames with random backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      len = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)))
                                         : 8'($urandom_range(1, MAX_LEN));
      fill_rand(int'(len));
      run_frame(len, $urandom_range(0, 4) == 0, 3);
    end
    rnd_ready = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_frame_rx_ctrl.md
# uart_frame_rx_ctrl

Receive-side frame controller placed directly after `uart_rx`. It sequences the receiver by owning its synchronous reset. It parses the byte stream into sync/length/payload/check frames and buffers the payload until the frame is validated. It then releases the payload on a ready/valid stream and reports frame status, recovering the receiver after any error.

## Interface
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `MAX_LEN`, 16: largest legal payload length (1..255).
- `TIMEOUT_CYCLES`, 480: inter-byte timeout in `clk` cycles (three byte times at 16x oversampling).
- `RESYNC_CYCLES`, 16: cycles `rx_rst` is held high after an error.
- `clk` in 1: 16x-bitrate clock, shared with `uart_rx`.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: byte from `uart_rx`.
- `rx_data_valid` in 1: one-cycle byte strobe from `uart_rx`.
- `rx_rst` out 1: drives `uart_rx` `rst`. Registered. Reset value 1.
- `out_data` out 8: payload byte. Reset value 0.
- `out_valid` out 1: payload byte available. Reset value 0.
- `out_last` out 1: qualifies the final payload byte. Reset value 0.
- `out_ready` in 1: downstream accepts the byte.
- `frame_ok` out 1: one-cycle pulse when a frame validates. Reset value 0.
- `frame_err` out 1: one-cycle error pulse. Reset value 0.
- `err_code` out 2: valid with `frame_err`. 0 BAD_LEN, 1 BAD_SUM, 2 TIMEOUT, 3 OVERRUN. Holds last value. Reset value 0.

## Operation
- States: IDLE, LEN, PAYLOAD, CHECK, DRAIN, RESYNC. The reset state is RESYNC with a full count, so `rx_rst` stays high for `RESYNC_CYCLES` cycles after `rst_n` releases.
- IDLE: a byte equal to `SYNC_BYTE` moves to LEN. Any other byte is ignored.
- LEN: a length byte L with 1 ≤ L ≤ `MAX_LEN` latches L, seeds the sum with L, clears the index, and moves to PAYLOAD. L = 0 or L > `MAX_LEN` gives a BAD_LEN error.
- PAYLOAD: each byte is written to `buf[idx]`, added to the sum modulo 256, and increments `idx`. After byte L the block moves to CHECK.
- CHECK: if the byte equals the sum, the block pulses `frame_ok` and moves to DRAIN. Otherwise it gives a BAD_SUM error.
- DRAIN:
  - Drives `out_data = buf[rd]`, `out_valid = 1`, and `out_last = (rd == L-1)`.
  - `rd` advances on `out_valid && out_ready`.
  - Acceptance of the last byte returns the block to IDLE.
  - Any `rx_data_valid` seen in DRAIN is discarded, pulses OVERRUN, and does not abort the drain.
- Error (BAD_LEN, BAD_SUM, TIMEOUT): pulse `frame_err` with its code, then enter RESYNC.
- RESYNC: `rx_rst = 1` for `RESYNC_CYCLES` cycles, then IDLE. Bytes arriving in RESYNC are ignored.
- Timeout: a counter runs in LEN, PAYLOAD and CHECK. It clears on every `rx_data_valid` and on state entry. When it reaches `TIMEOUT_CYCLES`, the block raises a TIMEOUT error.
- `rx_rst` is 0 in every state except RESYNC.
- `out_valid` drops only after the final handshake. Data is stable while stalled.

## Timing
- Each byte is sampled on the edge where `rx_data_valid = 1`. The state and status pulses change on that edge.
- `frame_ok` and the first `out_valid` both rise in the cycle after the check byte is sampled.
- `frame_err` is high in the cycle after the offending byte or the timeout compare. `rx_rst` rises in that same cycle.
- If `rx_data_valid` coincides with the timeout compare, the byte wins: it is processed and the counter clears.
- An OVERRUN pulse and an output handshake in the same cycle are independent. Both take effect.
- `rst_n` low mid-frame clears everything asynchronously. The partial frame is lost and no status pulse is issued.
- Zero-wait drain with `out_ready` held high gives one byte per cycle.

## Configuration
- `UART_FRAME_CHECKSUM_EN` defined: frames carry a check byte and the CHECK state is present, as described above.
- Not defined:
  - No CHECK state and no sum logic.
  - After payload byte L the block pulses `frame_ok` and enters DRAIN on the next edge.
  - BAD_SUM is never reported.

## Test plan
- Checksum enabled, `out_ready` = 1, input A5 03 11 22 33 69:
  - `frame_ok` pulses once.
  - `out_data` is 11, 22, 33 on consecutive cycles, with `out_last` high only on 33.
- Same frame with check byte 6A:
  - `frame_err`=1 with `err_code`=1 and no `out_valid`.
  - `rx_rst` is high for exactly 16 cycles, then the block is back in IDLE.
  - A following valid frame is received correctly.
- Input A5 00, then A5 11 (with `MAX_LEN` = 16): each length byte gives `err_code`=0 and a RESYNC.
- Input A5 03 11 followed by silence:
  - `frame_err` with `err_code`=2 exactly 480 cycles after the 11 strobe.
  - A strobe landing on cycle 480 prevents the error.
- During DRAIN, hold `out_ready` low for 50 cycles and inject byte 5A:
  - `err_code`=3 pulse.
  - `out_data` holds 11 while stalled.
  - All three bytes are delivered once `out_ready` rises.
- Assert `rst_n` low mid-PAYLOAD:
  - All outputs return to their reset values immediately.
  - `rx_rst` stays high for 16 cycles after release.
  - No `out_valid` appears.
